// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, long-latency issue/result, decode sources,
// register-file write port, scoreboard and FIFO occupancy.
interface wb_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int LL_DEPTH = 4
);
    localparam int CW = $clog2(LL_DEPTH + 1);

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_wdata;

    logic            ll_issue_valid;
    logic [4:0]      ll_issue_rd;

    // ll_valid/ll_ready: a result transfers on a cycle where both are high;
    // while ll_valid is high and ll_ready low the producer holds ll_rd/ll_wdata.
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_rd;
    logic [XLEN-1:0] ll_wdata;

    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic            hazard_stall;

    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;

    logic [31:0]     pending;
    logic [CW-1:0]   ll_count;

    modport master (
        output alu_valid, alu_rd, alu_wdata,
        output ll_issue_valid, ll_issue_rd,
        output ll_valid, ll_rd, ll_wdata,
        output rs1_reg, rs2_reg,
        input  ll_ready, hazard_stall,
        input  rf_we, rf_rd, rf_wdata,
        input  pending, ll_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wdata,
        input  ll_issue_valid, ll_issue_rd,
        input  ll_valid, ll_rd, ll_wdata,
        input  rs1_reg, rs2_reg,
        output ll_ready, hazard_stall,
        output rf_we, rf_rd, rf_wdata,
        output pending, ll_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results (fixed priority) and FIFO-buffered long-latency
// results share one registered RF write port; a 32-bit scoreboard drives the
// decode RAW stall. Optional WB_ARB_BYPASS_EN lets a result skip an empty FIFO.
module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int LL_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(LL_DEPTH);
    localparam int CW = $clog2(LL_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(LL_DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } ll_entry_t;

    ll_entry_t       fifo_q [LL_DEPTH];
    ll_entry_t       head;

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     pending_q, pending_d;

    logic            fifo_empty;
    logic            ll_ready;
    logic            push_req;
    logic            do_push;
    logic            do_pop;
    logic            do_bypass;
    logic            sel_valid;
    logic            clr_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_wdata;

    assign fifo_empty = (count_q == '0);
    // Depends on occupancy only, so a full FIFO cannot reuse a slot freed this cycle.
    assign ll_ready   = (count_q != FULL);
    assign push_req   = bus.ll_valid && ll_ready;
    assign do_pop     = !bus.alu_valid && !fifo_empty;

`ifdef WB_ARB_BYPASS_EN
    assign do_bypass  = push_req && fifo_empty && !bus.alu_valid;
`else
    assign do_bypass  = 1'b0;
`endif

    assign do_push    = push_req && !do_bypass;
    assign head       = fifo_q[rd_ptr_q];

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_wdata = '0;
        clr_valid = 1'b0;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_wdata = bus.alu_wdata;
        end else if (do_pop) begin
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_wdata = head.wdata;
            clr_valid = 1'b1;
        end else if (do_bypass) begin
            sel_valid = 1'b1;
            sel_rd    = bus.ll_rd;
            sel_wdata = bus.ll_wdata;
            clr_valid = 1'b1;
        end
    end

    always_comb begin
        rf_we_d    = sel_valid && (sel_rd != 5'd0);
        rf_rd_d    = sel_valid ? sel_rd : rf_rd_q;
        rf_wdata_d = sel_valid ? sel_wdata : rf_wdata_q;
    end

    // A same-cycle issue to the bit being cleared must win, so the set comes last.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid) begin
            pending_d[sel_rd] = 1'b0;
        end
        if (bus.ll_issue_valid && (bus.ll_issue_rd != 5'd0)) begin
            pending_d[bus.ll_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_q[wr_ptr_q] <= '{rd: bus.ll_rd, wdata: bus.ll_wdata};
        end
    end

    assign bus.ll_ready     = ll_ready;
    assign bus.hazard_stall = ((bus.rs1_reg != 5'd0) && pending_q[bus.rs1_reg]) ||
                              ((bus.rs2_reg != 5'd0) && pending_q[bus.rs2_reg]);
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_rd        = rf_rd_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.pending      = pending_q;
    assign bus.ll_count     = count_q;

    // Upstream must never issue to a register that is still awaiting its result.
    a_no_reissue: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.ll_issue_valid && (bus.ll_issue_rd != 5'd0)) |-> !pending_q[bus.ll_issue_rd]
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;
    localparam int XLEN     = 32;
    localparam int LL_DEPTH = 4;
    localparam int CW       = $clog2(LL_DEPTH + 1);
    localparam int E        = XLEN + 5;

    logic clk;
    logic rst_n;

    wb_arbiter_if #(.XLEN(XLEN), .LL_DEPTH(LL_DEPTH)) bus ();

    wb_arbiter #(.XLEN(XLEN), .LL_DEPTH(LL_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [E-1:0]    m_fifo[$];
    logic [E-1:0]    exp_q[$];
    logic [31:0]     m_pending;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wdata;

    // driver tasks
    task automatic drive_idle();
        bus.alu_valid      = 1'b0;
        bus.alu_rd         = '0;
        bus.alu_wdata      = '0;
        bus.ll_issue_valid = 1'b0;
        bus.ll_issue_rd    = '0;
        bus.ll_valid       = 1'b0;
        bus.ll_rd          = '0;
        bus.ll_wdata       = '0;
        bus.rs1_reg        = '0;
        bus.rs2_reg        = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic step();
        logic [E-1:0] w;
        logic         has;
        logic         byp;
        logic         clr;
        logic         push_ok;
        if (!rst_n) begin
            m_fifo.delete();
            m_pending = '0;
            m_we      = 1'b0;
            m_rd      = '0;
            m_wdata   = '0;
        end else begin
            push_ok = bus.ll_valid && (m_fifo.size() < LL_DEPTH);
            w   = '0;
            has = 1'b0;
            byp = 1'b0;
            clr = 1'b0;
            if (bus.alu_valid) begin
                w   = {bus.alu_rd, bus.alu_wdata};
                has = 1'b1;
            end else if (m_fifo.size() != 0) begin
                w   = m_fifo.pop_front();
                has = 1'b1;
                clr = 1'b1;
            end
`ifdef WB_ARB_BYPASS_EN
            else if (push_ok) begin
                w   = {bus.ll_rd, bus.ll_wdata};
                has = 1'b1;
                clr = 1'b1;
                byp = 1'b1;
            end
`endif
            if (push_ok && !byp) m_fifo.push_back({bus.ll_rd, bus.ll_wdata});
            if (clr) m_pending[w[E-1:XLEN]] = 1'b0;
            if (bus.ll_issue_valid && bus.ll_issue_rd != 5'd0) m_pending[bus.ll_issue_rd] = 1'b1;
            m_pending[0] = 1'b0;
            m_we = has && (w[E-1:XLEN] != 5'd0);
            if (has) begin
                m_rd    = w[E-1:XLEN];
                m_wdata = w[XLEN-1:0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        bus.alu_valid      = 1'b1;
        bus.alu_rd         = 5'd5;
        bus.alu_wdata      = 32'hA5A5_A5A5;
        bus.ll_issue_valid = 1'b1;
        bus.ll_issue_rd    = 5'd7;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.rf_we !== 1'b0) begin
                failures++;
                $display("FAIL reset_rf_we cycle %0d: got %b want 0", i, bus.rf_we);
            end
            checks++;
            if (bus.pending !== 32'h0) begin
                failures++;
                $display("FAIL reset_pending cycle %0d: got %h want 0", i, bus.pending);
            end
            checks++;
            if (bus.ll_count !== CW'(0)) begin
                failures++;
                $display("FAIL reset_ll_count cycle %0d: got %0d want 0", i, bus.ll_count);
            end
        end
        drive_idle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ll_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ll_ready: got %b want 1", bus.ll_ready);
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.pending !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: rf_we=%b pending=%h want 0/0", bus.rf_we, bus.pending);
        end
    endtask

    task automatic test_alu();
        drive_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_wdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL alu_write: got we=%b rd=%0d data=%h want 1/3/deadbeef",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        drive_idle();
        step();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL alu_idle_hold: got we=%b rd=%0d data=%h want 0/3/deadbeef",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_wdata = 32'h1111_2222;
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL alu_x0: got we=%b want 0", bus.rf_we);
        end
        drive_idle();
        step();
    endtask

    task automatic test_hazard();
        int   lat;
        logic seen;
        int   want_lat;
`ifdef WB_ARB_BYPASS_EN
        want_lat = 1;
`else
        want_lat = 2;
`endif
        drive_idle();
        bus.ll_issue_valid = 1'b1;
        bus.ll_issue_rd    = 5'd9;
        bus.rs1_reg        = 5'd9;
        step();
        bus.ll_issue_valid = 1'b0;
        checks++;
        if (bus.pending[9] !== 1'b1 || bus.hazard_stall !== 1'b1) begin
            failures++;
            $display("FAIL hazard_set: pending9=%b stall=%b want 1/1", bus.pending[9], bus.hazard_stall);
        end
        bus.rs1_reg = 5'd0;
        bus.rs2_reg = 5'd9;
        step();
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            failures++;
            $display("FAIL hazard_rs2: stall=%b want 1", bus.hazard_stall);
        end
        bus.rs2_reg = 5'd8;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            failures++;
            $display("FAIL hazard_other_reg: stall=%b want 0", bus.hazard_stall);
        end
        bus.rs1_reg  = 5'd9;
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd9;
        bus.ll_wdata = 32'h0000_0099;
        step();
        bus.ll_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 5) begin
            if (bus.rf_we === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (bus.hazard_stall !== 1'b1 || bus.pending[9] !== 1'b1) begin
                    failures++;
                    $display("FAIL hazard_hold: stall=%b pending9=%b want 1/1", bus.hazard_stall, bus.pending[9]);
                end
                step();
                lat++;
            end
        end
        checks++;
        if (!seen || lat != want_lat) begin
            failures++;
            $display("FAIL hazard_latency: seen=%b latency=%0d want %0d", seen, lat, want_lat);
        end
        checks++;
        if (bus.rf_rd !== 5'd9 || bus.rf_wdata !== 32'h99 || bus.hazard_stall !== 1'b0 ||
            bus.pending[9] !== 1'b0) begin
            failures++;
            $display("FAIL hazard_clear: rd=%0d data=%h stall=%b pending9=%b want 9/99/0/0",
                     bus.rf_rd, bus.rf_wdata, bus.hazard_stall, bus.pending[9]);
        end
        drive_idle();
        step();
    endtask

    task automatic test_priority();
        drive_idle();
        bus.ll_issue_valid = 1'b1;
        bus.ll_issue_rd    = 5'd4;
        step();
        bus.ll_issue_valid = 1'b0;
        bus.ll_valid       = 1'b1;
        bus.ll_rd          = 5'd4;
        bus.ll_wdata       = 32'h4444_0004;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(20 + i);
            bus.alu_wdata = 32'hA000_0000 + i;
            step();
            bus.ll_valid = 1'b0;
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(20 + i) || bus.pending[4] !== 1'b1) begin
                failures++;
                $display("FAIL priority_alu%0d: we=%b rd=%0d pending4=%b want 1/%0d/1",
                         i, bus.rf_we, bus.rf_rd, bus.pending[4], 20 + i);
            end
        end
        drive_idle();
        step();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd4 || bus.rf_wdata !== 32'h4444_0004 ||
            bus.pending[4] !== 1'b0) begin
            failures++;
            $display("FAIL priority_ll: we=%b rd=%0d data=%h pending4=%b want 1/4/44440004/0",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pending[4]);
        end
        step();
    endtask

    task automatic test_fifo_full();
        logic [E-1:0] e;
        drive_idle();
        exp_q.delete();
        bus.alu_valid = 1'b1;
        for (int i = 0; i < LL_DEPTH; i++) begin
            bus.alu_rd    = 5'd1;
            bus.alu_wdata = $urandom;
            bus.ll_valid  = 1'b1;
            bus.ll_rd     = 5'(10 + i);
            bus.ll_wdata  = $urandom;
            exp_q.push_back({bus.ll_rd, bus.ll_wdata});
            step();
        end
        bus.ll_valid = 1'b0;
        checks++;
        if (bus.ll_count !== CW'(LL_DEPTH) || bus.ll_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state: count=%0d ready=%b want %0d/0", bus.ll_count, bus.ll_ready, LL_DEPTH);
        end
        step();
        checks++;
        if (bus.ll_count !== CW'(LL_DEPTH) || bus.ll_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_starved: count=%0d ready=%b want %0d/0", bus.ll_count, bus.ll_ready, LL_DEPTH);
        end
        bus.alu_valid = 1'b0;
        for (int i = 0; i < LL_DEPTH; i++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== e[E-1:XLEN] || bus.rf_wdata !== e[XLEN-1:0]) begin
                failures++;
                $display("FAIL full_drain%0d: we=%b rd=%0d data=%h want 1/%0d/%h",
                         i, bus.rf_we, bus.rf_rd, bus.rf_wdata, e[E-1:XLEN], e[XLEN-1:0]);
            end
            checks++;
            if (bus.ll_count !== CW'(LL_DEPTH - 1 - i) || bus.ll_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_drain_count%0d: count=%0d ready=%b want %0d/1",
                         i, bus.ll_count, bus.ll_ready, LL_DEPTH - 1 - i);
            end
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL full_after: we=%b want 0", bus.rf_we);
        end
    endtask

    task automatic test_bypass();
        drive_idle();
        bus.ll_valid = 1'b1;
        bus.ll_rd    = 5'd12;
        bus.ll_wdata = 32'h0000_1234;
        step();
        bus.ll_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd12 || bus.rf_wdata !== 32'h1234 ||
            bus.ll_count !== CW'(0)) begin
            failures++;
            $display("FAIL bypass_n1: we=%b rd=%0d data=%h count=%0d want 1/12/1234/0",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.ll_count);
        end
`else
        checks++;
        if (bus.rf_we !== 1'b0 || bus.ll_count !== CW'(1)) begin
            failures++;
            $display("FAIL nobypass_n1: we=%b count=%0d want 0/1", bus.rf_we, bus.ll_count);
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd12 || bus.rf_wdata !== 32'h1234 ||
            bus.ll_count !== CW'(0)) begin
            failures++;
            $display("FAIL nobypass_n2: we=%b rd=%0d data=%h count=%0d want 1/12/1234/0",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.ll_count);
        end
`endif
        step();
    endtask

    task automatic test_random();
        logic            exp_stall;
        logic            accepted;
        logic [4:0]      r;
        drive_idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.rs1_reg   = 5'($urandom_range(0, 31));
            bus.rs2_reg   = 5'($urandom_range(0, 31));
            bus.alu_valid = ($urandom_range(0, 99) < 40);
            bus.alu_rd    = 5'($urandom_range(0, 31));
            bus.alu_wdata = $urandom;
            if (!bus.ll_valid) begin
                bus.ll_valid = ($urandom_range(0, 99) < 50);
                bus.ll_rd    = 5'($urandom_range(0, 31));
                bus.ll_wdata = $urandom;
            end
            r = 5'($urandom_range(0, 31));
            bus.ll_issue_valid = ($urandom_range(0, 99) < 30) && !m_pending[r];
            bus.ll_issue_rd    = r;
            #1;
            exp_stall = (bus.rs1_reg != 0 && m_pending[bus.rs1_reg]) ||
                        (bus.rs2_reg != 0 && m_pending[bus.rs2_reg]);
            checks++;
            if (bus.hazard_stall !== exp_stall || bus.ll_ready !== (m_fifo.size() < LL_DEPTH)) begin
                failures++;
                $display("FAIL rand_comb cyc %0d: stall=%b ready=%b want %b/%b",
                         cyc, bus.hazard_stall, bus.ll_ready, exp_stall, m_fifo.size() < LL_DEPTH);
            end
            accepted = bus.ll_valid && (m_fifo.size() < LL_DEPTH);
            step();
            if (accepted) bus.ll_valid = 1'b0;
            checks++;
            if (bus.rf_we !== m_we || (m_we && (bus.rf_rd !== m_rd || bus.rf_wdata !== m_wdata))) begin
                failures++;
                $display("FAIL rand_write cyc %0d: we=%b rd=%0d data=%h want %b/%0d/%h",
                         cyc, bus.rf_we, bus.rf_rd, bus.rf_wdata, m_we, m_rd, m_wdata);
            end
            checks++;
            if (bus.pending !== m_pending || bus.ll_count !== CW'(m_fifo.size())) begin
                failures++;
                $display("FAIL rand_state cyc %0d: pending=%h count=%0d want %h/%0d",
                         cyc, bus.pending, bus.ll_count, m_pending, m_fifo.size());
            end
        end
        drive_idle();
        for (int i = 0; i < LL_DEPTH + 2; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        m_pending = '0;
        m_we      = 1'b0;
        m_rd      = '0;
        m_wdata   = '0;
        test_reset();
        test_alu();
        test_hazard();
        test_priority();
        test_fifo_full();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard that drives the single register-file write port. It merges two result sources, the single-cycle ALU path and the long-latency path (load/mul/div), onto one registered write port. Long-latency results are buffered in a small FIFO. A 32-bit pending-register scoreboard gives decode a RAW hazard stall. It sits between the execute/memory stages and the register file.

## Interface
- XLEN, 32, data width.
- LL_DEPTH, 4, long-latency result FIFO depth (power of two, ≥2).

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_wdata  in  XLEN  ALU result.
- ll_issue_valid  in  1  long-latency op issued this cycle.
- ll_issue_rd  in  5  destination of the issued long-latency op.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  FIFO can accept a result.
- ll_rd  in  5  long-latency result destination.
- ll_wdata  in  XLEN  long-latency result.
- rs1_reg  in  5  decode source 1.
- rs2_reg  in  5  decode source 2.
- hazard_stall  out  1  a decode source is pending.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- pending  out  32  scoreboard; bit i set means xi awaits a long-latency result.
- ll_count  out  $clog2(LL_DEPTH+1)  FIFO occupancy.

## Operation
- Reset (rst_n=0 at the clock edge):
  - rf_we=0, rf_rd=0, rf_wdata=0, pending=0, ll_count=0.
  - FIFO is flushed and in-flight entries are discarded.
  - After reset, ll_ready=1.
- Long-latency intake:
  - ll_ready = (ll_count != LL_DEPTH).
  - A push occurs when ll_valid && ll_ready.
  - Entries are {rd, wdata}, popped in order.
- Arbitration, evaluated each cycle; the selection registers onto rf_* at the next edge:
  - ALU has fixed priority. If alu_valid, the write port takes {alu_rd, alu_wdata}.
  - Otherwise, if the FIFO is non-empty, the head is popped onto the write port.
  - Otherwise rf_we=0. rf_rd and rf_wdata hold their previous values.
- x0 filtering:
  - Any selected write with rd==0 produces rf_we=0.
  - A FIFO pop with rd==0 still consumes the entry.
- Scoreboard:
  - Set pending[ll_issue_rd] on ll_issue_valid when ll_issue_rd != 0.
  - Clear pending[rd] when a FIFO entry is popped onto the write port.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - pending[0] is constant 0.
- hazard_stall = (rs1_reg!=0 && pending[rs1_reg]) || (rs2_reg!=0 && pending[rs2_reg]). Combinational from current state.
- Protocol rule: upstream never issues a long-latency op to a register that is already pending. A simulation assertion flags any violation.
- FIFO full with ll_valid high: ll_ready=0; the producer holds ll_rd and ll_wdata stable until accepted.
- Simultaneous push and pop: ll_count is unchanged. When full, ll_ready stays 0 that cycle (no same-cycle slot reuse).
- Starvation: continuous alu_valid starves FIFO pops. This is by design; upstream guarantees ALU bubbles.

## Timing
- ALU to write port: alu_valid in cycle N gives rf_we=1 in cycle N+1.
- Long-latency result: accepted in cycle N; earliest rf_we in cycle N+2 (FIFO write, then pop).
  - With WB_ARB_BYPASS_EN, earliest rf_we is cycle N+1.
- pending clears at the same edge rf_we rises for that result. In that cycle hazard_stall drops and the register file's write-through bypass supplies the value to decode.
- ll_ready and hazard_stall depend only on registered state plus the rs*/ll_count inputs. There is no path from ll_valid to ll_ready.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - Bypass applies when ll_valid && ll_ready, the FIFO is empty and alu_valid=0.
  - The result goes straight to the write port at the next edge without being pushed.
  - The scoreboard clear happens at that edge.
  - ll_count stays 0.
- WB_ARB_BYPASS_EN undefined: every long-latency result passes through the FIFO, giving a minimum 2-cycle latency.

## Test plan
- Reset:
  - Stimulus: drive alu_valid=1, alu_rd=5 and ll_issue_valid=1, ll_issue_rd=7, with rst_n=0 asserted for 2 cycles.
  - Required: rf_we=0, pending=0 and ll_count=0 throughout; ll_ready=1 after release.
- ALU path:
  - Stimulus: alu_valid=1, alu_rd=3, alu_wdata=0xDEADBEEF in cycle N.
  - Required: rf_we=1, rf_rd=3, rf_wdata=0xDEADBEEF in cycle N+1.
  - Stimulus: alu_rd=0. Required: rf_we=0.
- Scoreboard and hazard:
  - Stimulus: issue ll to x9; rs1_reg=9.
  - Required: hazard_stall=1 and pending[9]=1 until the x9 result pops.
  - After the pop: rf_we=1, rf_rd=9, and hazard_stall=0 in that same cycle.
- Priority:
  - Stimulus: a FIFO holding an x4 result, with alu_valid high for 3 cycles.
  - Required: three ALU writes, then the x4 write in the 4th write cycle; pending[4] clears only then.
- FIFO full:
  - Stimulus: push LL_DEPTH=4 results while alu_valid=1 continuously.
  - Required: ll_count=4 and ll_ready=0, with no push lost.
  - Stimulus: drop alu_valid. Required: four writes in FIFO order and ll_ready=1 after the first pop.
- Bypass (WB_ARB_BYPASS_EN):
  - Stimulus: with the FIFO empty and the ALU idle, ll_valid=1, ll_rd=12, ll_wdata=0x1234 in cycle N.
  - Required: rf_we=1, rf_rd=12 in cycle N+1, with ll_count=0. Without the macro the write lands in N+2.
